hdmi_grid_average: RTL and testbench

//  Consumes the decoded HDMI pixel stream (hdmi_clk domain) and box-averages it into a

---
 rtl/hdmi_grid_average.sv | 153 +++++++++++++++
 tb/tb_hdmi_grid_average.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_grid_average.sv
// hdmi_grid_average: box-averages the decoded HDMI pixel stream into a
// GRID_W x GRID_H grid of 24-bit RGB cells. One row of per-column
// accumulators is flushed into a double-buffered RAM after each cell row.
// A registered random-access read port always sees the last complete frame.
module hdmi_grid_average #(
  parameter int GRID_W      = 8,
  parameter int GRID_H      = 8,
  parameter int CELL_W_LOG2 = 6,
  parameter int CELL_H_LOG2 = 5,
  localparam int CELLS      = GRID_W * GRID_H,
  localparam int A          = $clog2(CELLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync,
  input  logic          rgb_valid,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  input  logic [11:0]   xaddr,
  input  logic [11:0]   yaddr,
  input  logic [A-1:0]  rd_addr,
  output logic [23:0]   rd_data,
  output logic          frame_strobe,
  output logic [7:0]    frame_count,
  output logic          overrun
);

  localparam int SHIFT = CELL_W_LOG2 + CELL_H_LOG2;
  localparam int AW    = 8 + SHIFT;
  localparam int XB    = $clog2(GRID_W);
  localparam int YB    = $clog2(GRID_H);

  localparam logic [11:0] GRID_W12 = 12'(GRID_W);
  localparam logic [11:0] GRID_H12 = 12'(GRID_H);
  localparam logic [11:0] LAST_X   = 12'((GRID_W << CELL_W_LOG2) - 1);

  typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

  state_t          state;
  logic [XB-1:0]   flush_idx;
  logic [YB-1:0]   cy_latch;
  logic            bank_sel;
  logic            vsync_d;
  logic [AW-1:0]   acc [GRID_W][3];
  logic [23:0]     mem [2*CELLS];

  logic [11:0]     cx_full;
  logic [11:0]     cy_full;
  logic [XB-1:0]   cx;
  logic [YB-1:0]   cy;
  logic            in_grid;
  logic            last_pixel;
  logic            vsync_rise;
  logic [7:0]      pix [3];

  logic            wr_en;
  logic [A:0]      wr_addr;
  logic [23:0]     wr_data;

  assign cx_full    = xaddr >> CELL_W_LOG2;
  assign cy_full    = yaddr >> CELL_H_LOG2;
  assign cx         = cx_full[XB-1:0];
  assign cy         = cy_full[YB-1:0];
  assign in_grid    = (cx_full < GRID_W12) && (cy_full < GRID_H12);
  assign last_pixel = (xaddr == LAST_X) && (&yaddr[CELL_H_LOG2-1:0]);
  assign vsync_rise = vsync & ~vsync_d;
  assign pix[0]     = r;
  assign pix[1]     = g;
  assign pix[2]     = b;

  // Flush write: the cell being flushed goes to the bank not currently readable.
  // The grid is a power of two on each axis, so cy*GRID_W+i is a plain concatenation.
  always_comb begin
    wr_en   = (state == FLUSH) && !vsync_rise;
    wr_addr = {~bank_sel, cy_latch, flush_idx};
    wr_data = {acc[flush_idx][0][AW-1:SHIFT],
               acc[flush_idx][1][AW-1:SHIFT],
               acc[flush_idx][2][AW-1:SHIFT]};
  end

  // Cell RAM holding both banks; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read of the readable bank; the address space exactly covers the grid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[{bank_sel, rd_addr}];
  end

  // Main control: accumulate, flush a cell row, publish a frame, restart on vsync.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ACCUM;
      flush_idx    <= '0;
      cy_latch     <= '0;
      bank_sel     <= 1'b0;
      vsync_d      <= 1'b0;
      frame_strobe <= 1'b0;
      frame_count  <= '0;
      overrun      <= 1'b0;
      for (int i = 0; i < GRID_W; i++)
        for (int c = 0; c < 3; c++)
          acc[i][c] <= '0;
    end else begin
      vsync_d      <= vsync;
      frame_strobe <= 1'b0;
      case (state)
        ACCUM: begin
          if (rgb_valid && in_grid) begin
            for (int c = 0; c < 3; c++)
              acc[cx][c] <= acc[cx][c] + AW'(pix[c]);
            if (last_pixel) begin
              state     <= FLUSH;
              cy_latch  <= cy;
              flush_idx <= '0;
            end
          end
        end
        FLUSH: begin
          if (rgb_valid && in_grid) overrun <= 1'b1;
          for (int c = 0; c < 3; c++)
            acc[flush_idx][c] <= '0;
          flush_idx <= flush_idx + XB'(1);
          if (flush_idx == XB'(GRID_W - 1)) begin
            if (cy_latch == YB'(GRID_H - 1)) begin
              state        <= DONE;
              frame_strobe <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          bank_sel    <= ~bank_sel;
          frame_count <= frame_count + 8'd1;
          state       <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
      if (vsync_rise) begin
        state        <= ACCUM;
        frame_strobe <= 1'b0;
        for (int i = 0; i < GRID_W; i++)
          for (int c = 0; c < 3; c++)
            acc[i][c] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_grid_average.sv
// tb_hdmi_grid_average: drives whole frames on a 2x2 grid of 2x2-pixel cells,
// computes the expected cell averages directly from the frame images and
// compares the read port, strobe count, frame counter and overrun flag.
module tb_hdmi_grid_average;

  localparam int GW    = 2;
  localparam int GH    = 2;
  localparam int CWL   = 1;
  localparam int CHL   = 1;
  localparam int COLS  = GW << CWL;
  localparam int ROWS  = GH << CHL;
  localparam int NCELL = GW * GH;
  localparam int BLANK = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        rgb_valid;
  logic [7:0]  r, g, b;
  logic [11:0] xaddr, yaddr;
  logic [1:0]  rd_addr;
  logic [23:0] rd_data;
  logic        frame_strobe;
  logic [7:0]  frame_count;
  logic        overrun;

  int          n_checks;
  int          n_fail;
  int          strobe_cnt = 0;
  int          exp_strobes;
  int          exp_fc;
  logic        exp_ovr;
  logic [7:0]  fr_r [ROWS][COLS];
  logic [7:0]  fr_g [ROWS][COLS];
  logic [7:0]  fr_b [ROWS][COLS];
  logic [23:0] exp_cur  [NCELL];
  logic [23:0] exp_next [NCELL];

  hdmi_grid_average #(
    .GRID_W(GW), .GRID_H(GH), .CELL_W_LOG2(CWL), .CELL_H_LOG2(CHL)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .rgb_valid(rgb_valid),
    .r(r), .g(g), .b(b), .xaddr(xaddr), .yaddr(yaddr),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_strobe(frame_strobe),
    .frame_count(frame_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Count every cycle the strobe is high; one-cycle pulses give one count per frame.
  always @(negedge clk) begin
    if (reset === 1'b1 && frame_strobe === 1'b1) strobe_cnt++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int x, input int y,
                               input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
    rgb_valid = v;
    xaddr     = 12'(x);
    yaddr     = 12'(y);
    r         = pr;
    g         = pg;
    b         = pb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    idle(2);
    vsync = 1'b0;
    idle(4);
  endtask

  task automatic read_cell(input int addr, output logic [23:0] data);
    rd_addr = 2'(addr);
    idle(1);
    data = rd_data;
  endtask

  task automatic fill_uniform(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        fr_r[y][x] = pr;
        fr_g[y][x] = pg;
        fr_b[y][x] = pb;
      end
  endtask

  task automatic fill_random();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        fr_r[y][x] = 8'($urandom);
        fr_g[y][x] = 8'($urandom);
        fr_b[y][x] = 8'($urandom);
      end
  endtask

  // Reference: each cell is the truncated mean of its block of the frame image.
  task automatic compute_expected();
    for (int cy = 0; cy < GH; cy++)
      for (int cx = 0; cx < GW; cx++) begin
        int sr, sg, sb;
        sr = 0; sg = 0; sb = 0;
        for (int dy = 0; dy < (1 << CHL); dy++)
          for (int dx = 0; dx < (1 << CWL); dx++) begin
            sr += int'(fr_r[(cy << CHL) + dy][(cx << CWL) + dx]);
            sg += int'(fr_g[(cy << CHL) + dy][(cx << CWL) + dx]);
            sb += int'(fr_b[(cy << CHL) + dy][(cx << CWL) + dx]);
          end
        exp_next[cy * GW + cx] = {8'(sr / (1 << (CWL + CHL))),
                                  8'(sg / (1 << (CWL + CHL))),
                                  8'(sb / (1 << (CWL + CHL)))};
      end
  endtask

  task automatic send_line(input int y, input bit oog, input bit inject, input bit done_read);
    logic [23:0] d;
    for (int x = 0; x < COLS; x++)
      applyStimulus(1'b1, x, y, fr_r[y][x], fr_g[y][x], fr_b[y][x]);
    if (inject) begin
      applyStimulus(1'b0, 0, 0, 8'h00, 8'h00, 8'h00);
      applyStimulus(1'b1, 0, 2, 8'hFF, 8'hFF, 8'hFF);
    end
    if (done_read) begin
      idle(2);
      checkOutput("strobe_in_done", frame_strobe, 1);
      rd_addr = 2'd0;
      idle(1);
      d = rd_data;
      checkOutput("read_at_swap_old", d, exp_cur[0]);
      idle(1);
      d = rd_data;
      checkOutput("read_after_swap_new", d, exp_next[0]);
    end
    if (oog)
      for (int x = COLS; x < 2 * COLS; x++) applyStimulus(1'b1, x, y, 8'hFF, 8'hFF, 8'hFF);
    idle(BLANK);
  endtask

  task automatic send_frame(input bit vs, input bit oog, input int nlines,
                            input bit inject, input bit done_read);
    if (vs) pulse_vsync();
    for (int y = 0; y < nlines; y++)
      send_line(y, oog, inject && (y == 1), done_read && (y == ROWS - 1));
    if (oog && nlines == ROWS)
      for (int y = ROWS; y < 2 * ROWS; y++) begin
        for (int x = 0; x < 2 * COLS; x++) applyStimulus(1'b1, x, y, 8'hFF, 8'hFF, 8'hFF);
        idle(BLANK);
      end
  endtask

  task automatic finish_frame();
    logic [23:0] d;
    exp_strobes++;
    exp_fc = (exp_fc + 1) % 256;
    for (int i = 0; i < NCELL; i++) exp_cur[i] = exp_next[i];
    checkOutput("strobe_count", strobe_cnt, exp_strobes);
    checkOutput("frame_count", frame_count, exp_fc);
    checkOutput("overrun", overrun, exp_ovr);
    for (int i = 0; i < NCELL; i++) begin
      read_cell(i, d);
      checkOutput($sformatf("cell%0d", i), d, exp_cur[i]);
    end
  endtask

  task automatic full_frame(input bit oog, input bit inject, input bit done_read);
    compute_expected();
    send_frame(1'b1, oog, ROWS, inject, done_read);
    finish_frame();
  endtask

  initial begin
    logic [23:0] d;
    int          k;
    n_checks = 0; n_fail = 0; exp_strobes = 0; exp_fc = 0; exp_ovr = 1'b0;
    reset = 1'b0; vsync = 1'b0; rgb_valid = 1'b0;
    r = '0; g = '0; b = '0; xaddr = '0; yaddr = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_strobe", frame_strobe, 0);
    checkOutput("rst_frame_count", frame_count, 0);
    checkOutput("rst_overrun", overrun, 0);
    reset = 1'b1;
    idle(3);

    // Uniform frame.
    fill_uniform(8'h40, 8'h80, 8'hC0);
    full_frame(1'b0, 1'b0, 1'b0);
    read_cell(3, d);
    checkOutput("uniform_literal", d, 24'h4080C0);

    // Truncating average in cell (1,0).
    fill_random();
    fr_r[0][2] = 8'd10; fr_r[0][3] = 8'd20; fr_r[1][2] = 8'd30; fr_r[1][3] = 8'd41;
    full_frame(1'b0, 1'b0, 1'b0);
    read_cell(1, d);
    checkOutput("cell10_r", d[23:16], 8'h19);

    // Random frames with out-of-grid pixels around them.
    for (int f = 0; f < 2; f++) begin
      fill_random();
      full_frame(1'b1, 1'b0, 1'b0);
    end

    // Aborted partial frame leaves the readable frame alone and carries nothing over.
    k = ($urandom_range(0, 1) == 0) ? 1 : 3;
    fill_random();
    send_frame(1'b1, 1'b0, k, 1'b0, 1'b0);
    pulse_vsync();
    checkOutput("abort_strobes", strobe_cnt, exp_strobes);
    checkOutput("abort_frame_count", frame_count, exp_fc);
    read_cell(0, d);
    checkOutput("abort_keeps_cell0", d, exp_cur[0]);
    fill_uniform(8'h01, 8'h01, 8'h01);
    compute_expected();
    send_frame(1'b0, 1'b0, ROWS, 1'b0, 1'b0);
    finish_frame();
    read_cell(2, d);
    checkOutput("after_abort_literal", d, 24'h010101);

    // Read port across the bank swap.
    fill_uniform(8'h77, 8'h55, 8'h33);
    full_frame(1'b0, 1'b0, 1'b1);

    // Pixel during a row flush is dropped and latches overrun.
    fill_random();
    compute_expected();
    send_frame(1'b1, 1'b0, ROWS, 1'b1, 1'b0);
    exp_ovr = 1'b1;
    finish_frame();
    fill_random();
    full_frame(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    fill_random();
    send_frame(1'b1, 1'b0, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 2, fr_r[2][0], fr_g[2][0], fr_b[2][0]);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_rd_data", rd_data, 0);
    checkOutput("midrst_frame_count", frame_count, 0);
    checkOutput("midrst_overrun", overrun, 0);
    checkOutput("midrst_strobe", frame_strobe, 0);
    idle(2);
    reset = 1'b1;
    exp_fc = 0;
    exp_ovr = 1'b0;
    idle(2);
    fill_random();
    full_frame(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
